dvp_frame_gen: RTL and testbench

Synthesisable DVP/CMOS camera-sensor emulator producing `cmos_vsyn`, `cmos_href` and 8-bit `cmos_data` frames of RGB565 pixels, two bytes per pixel. It replaces ad-hoc bench stimulus with a parametrised source usable both in simulation and on hardware, where it is muxed in front of the camera capture path for bring-up. It adds:
- selectable pattern modes;
- frame counting;
- a start/stop handshake;
- a 16-bit pixel mirror port for scoreboarding.

---
 rtl/dvp_pkg.sv | 35 +++
 rtl/dvp_pattern.sv | 49 ++++
 rtl/dvp_frame_gen.sv | 189 ++++++++++++++++++
 tb/tb_dvp_frame_gen.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP frame generator.
package dvp_pkg;

  typedef enum logic [1:0] {
    MODE_LFSR  = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_BARS  = 2'd2,
    MODE_FIXED = 2'd3
  } dvp_mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StVsync,
    StVbp,
    StHblank,
    StActive
  } dvp_state_e;

  // RGB565 colour bars, left to right.
  localparam logic [15:0] BAR [0:7] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  // Galois taps for x^16+x^14+x^13+x^11+1 in a right-shifting register.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    umax = (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dvp_pattern.sv
// Pixel pattern source: combinational pixel for column x / line y, plus the LFSR state.
module dvp_pattern
  import dvp_pkg::*;
#(
  parameter int unsigned COL  = 1024,
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int unsigned XW   = 10,
  parameter int unsigned YW   = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          step_i,
  input  dvp_mode_e     mode_i,
  input  logic [15:0]   color_i,
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  output logic [15:0]   px_o
);

  logic [15:0] lfsr_q;
  logic [15:0] x16;
  logic [15:0] y16;
  logic [2:0]  bar_idx;

  // LFSR restarts from the seed each frame so all frames match; advances once per pixel.
  always_ff @(posedge clk_i) begin
    if (rst_i || load_i) begin
      lfsr_q <= SEED;
    end else if (step_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  // Pixel value selected by the frame's latched mode.
  always_comb begin
    x16     = 16'(x_i);
    y16     = 16'(y_i);
    bar_idx = 3'((32'(x_i) * 32'd8) / COL);
    px_o    = 16'h0000;
    case (mode_i)
      MODE_LFSR:  px_o = lfsr_q;
      MODE_RAMP:  px_o = x16 + y16;
      MODE_BARS:  px_o = BAR[bar_idx];
      MODE_FIXED: px_o = color_i;
    endcase
  end

endmodule

// File: rtl/dvp_frame_gen.sv
// DVP/CMOS camera-sensor emulator: vsync/href/byte stream of RGB565 frames.
module dvp_frame_gen
  import dvp_pkg::*;
#(
  parameter int unsigned ROW     = 720,
  parameter int unsigned COL     = 1024,
  parameter int unsigned H_BLANK = 100,
  parameter int unsigned VS_LEN  = 2601,
  parameter int unsigned VBP     = 16,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] num_frames,
  input  logic [1:0]  mode,
  input  logic [15:0] cfg_color,
  output logic        cmos_vsyn,
  output logic        cmos_href,
  output logic [7:0]  cmos_data,
  output logic        px_strb,
  output logic [15:0] px_data,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int unsigned LineBytes = 2 * COL;
  localparam int unsigned CntMax    = umax(umax(VS_LEN, VBP), umax(H_BLANK, LineBytes));
  localparam int unsigned CW        = $clog2(CntMax + 1);
  localparam int unsigned LW        = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int unsigned XW        = (COL > 1) ? $clog2(COL) : 1;
  // A zero-length horizontal blank goes straight to the active bytes.
  localparam dvp_state_e  LineStart = (H_BLANK == 0) ? StActive : StHblank;

  dvp_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [LW-1:0]  line_q, line_d;
  logic           stop_q, stop_d;
  logic [15:0]    fcnt_q, fcnt_d;
  dvp_mode_e      mode_q;
  logic [15:0]    color_q;
  logic           frame_end;
  logic           vs_entry;
  logic           act_d;
  logic           step;
  logic [XW-1:0]  px_x;
  logic [15:0]    px;

  logic           vsyn_q, href_q, strb_q, busy_q, done_q;
  logic [7:0]     data_q;
  logic [15:0]    pxd_q;

  assign act_d    = (state_d == StActive);
  assign step     = act_d && cnt_d[0];
  assign vs_entry = (state_d == StVsync) && (state_q != StVsync);
  assign px_x     = XW'(cnt_d >> 1);

  dvp_pattern #(
    .COL  (COL),
    .SEED (SEED),
    .XW   (XW),
    .YW   (LW)
  ) u_pattern (
    .clk_i   (CLK),
    .rst_i   (RST),
    .load_i  (vs_entry),
    .step_i  (step),
    .mode_i  (mode_q),
    .color_i (color_q),
    .x_i     (px_x),
    .y_i     (line_d),
    .px_o    (px)
  );

  // Next state: cnt counts cycles within a state; in StActive it is the byte index.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    line_d    = line_q;
    stop_d    = stop_q;
    fcnt_d    = fcnt_q;
    frame_end = 1'b0;
    if (state_q != StIdle && stop) begin
      stop_d = 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start) begin
          state_d = StVsync;
          stop_d  = 1'b0;
          fcnt_d  = 16'h0000;
        end
      end
      StVsync: begin
        if (cnt_q == CW'(VS_LEN - 1)) begin
          cnt_d   = '0;
          line_d  = '0;
          state_d = (VBP == 0) ? LineStart : StVbp;
        end
      end
      StVbp: begin
        if (cnt_q == CW'(VBP - 1)) begin
          cnt_d   = '0;
          state_d = LineStart;
        end
      end
      StHblank: begin
        if (cnt_q == CW'(H_BLANK - 1)) begin
          cnt_d   = '0;
          state_d = StActive;
        end
      end
      StActive: begin
        if (cnt_q == CW'(LineBytes - 1)) begin
          cnt_d = '0;
          if (line_q == LW'(ROW - 1)) begin
            frame_end = 1'b1;
            fcnt_d    = fcnt_q + 16'd1;
            // A stop arriving on the final byte still ends the run here.
            if (stop_q || stop || (num_frames != 16'd0 && fcnt_d == num_frames)) begin
              state_d = StIdle;
            end else begin
              state_d = StVsync;
            end
          end else begin
            line_d  = line_q + LW'(1);
            state_d = LineStart;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State plus outputs registered from the next state, so every output is a flop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      line_q  <= '0;
      stop_q  <= 1'b0;
      fcnt_q  <= 16'h0000;
      mode_q  <= MODE_LFSR;
      color_q <= 16'h0000;
      vsyn_q  <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
      strb_q  <= 1'b0;
      pxd_q   <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      stop_q  <= stop_d;
      fcnt_q  <= fcnt_d;
      if (vs_entry) begin
        mode_q  <= dvp_mode_e'(mode);
        color_q <= cfg_color;
      end
      vsyn_q <= (state_d == StVsync);
      href_q <= act_d;
      data_q <= act_d ? (cnt_d[0] ? px[7:0] : px[15:8]) : 8'h00;
      strb_q <= step;
      if (step) begin
        pxd_q <= px;
      end
      busy_q <= (state_d != StIdle);
      done_q <= frame_end;
    end
  end

  assign cmos_vsyn  = vsyn_q;
  assign cmos_href  = href_q;
  assign cmos_data  = data_q;
  assign px_strb    = strb_q;
  assign px_data    = pxd_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_dvp_frame_gen.sv
// Scoreboard bench for dvp_frame_gen with a small-geometry configuration.
module tb_dvp_frame_gen;

  localparam int unsigned ROW     = 4;
  localparam int unsigned COL     = 8;
  localparam int unsigned H_BLANK = 3;
  localparam int unsigned VS_LEN  = 5;
  localparam int unsigned VBP     = 2;
  localparam logic [15:0] SEED    = 16'hACE1;
  localparam int unsigned FLEN    = VS_LEN + VBP + ROW * (H_BLANK + 2 * COL);

  typedef struct packed {
    logic [15:0] fcnt;
    logic        last;
  } frm_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] num_frames = 16'd0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] cfg_color = 16'h0000;
  logic        cmos_vsyn, cmos_href, px_strb, busy, frame_done;
  logic [7:0]  cmos_data;
  logic [15:0] px_data, frame_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0]  exp_byte[$];
  logic [15:0] exp_px[$];
  frm_t        exp_frm[$];
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  dvp_frame_gen #(
    .ROW     (ROW),
    .COL     (COL),
    .H_BLANK (H_BLANK),
    .VS_LEN  (VS_LEN),
    .VBP     (VBP),
    .SEED    (SEED)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .start      (start),
    .stop       (stop),
    .num_frames (num_frames),
    .mode       (mode),
    .cfg_color  (cfg_color),
    .cmos_vsyn  (cmos_vsyn),
    .cmos_href  (cmos_href),
    .cmos_data  (cmos_data),
    .px_strb    (px_strb),
    .px_data    (px_data),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Polynomial x^16+x^14+x^13+x^11+1: exponents 16,14,13,11 map to bits 15,13,12,10.
  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    logic [15:0] taps;
    taps = (16'h1 << 15) | (16'h1 << 13) | (16'h1 << 12) | (16'h1 << 10);
    lfsr_adv = (s >> 1) ^ (s[0] ? taps : 16'h0000);
  endfunction

  // Expected byte/pixel stream of one whole frame plus its end-of-frame record.
  task automatic push_frame(input logic [1:0] m, input logic [15:0] col,
                            input logic [15:0] fc, input logic last);
    logic [15:0] lf;
    logic [15:0] p;
    frm_t f;
    lf = SEED;
    for (int y = 0; y < int'(ROW); y++) begin
      for (int x = 0; x < int'(COL); x++) begin
        case (m)
          2'd0:    p = lf;
          2'd1:    p = 16'(x + y);
          2'd2:    p = bars[(x * 8) / int'(COL)];
          default: p = col;
        endcase
        exp_byte.push_back(p[15:8]);
        exp_byte.push_back(p[7:0]);
        exp_px.push_back(p);
        lf = lfsr_adv(lf);
      end
    end
    f.fcnt = fc;
    f.last = last;
    exp_frm.push_back(f);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [15:0] col, input logic [15:0] nf);
    mode = m;
    cfg_color = col;
    num_frames = nf;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("vsyn_after_start", 32'(cmos_vsyn), 32'd1);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("fcnt_after_start", 32'(frame_cnt), 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", 32'(busy === 1'b0), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vsyn"}, 32'(cmos_vsyn), 32'd0);
    chk({tag, "_href"}, 32'(cmos_href), 32'd0);
    chk({tag, "_data"}, 32'(cmos_data), 32'd0);
    chk({tag, "_strb"}, 32'(px_strb), 32'd0);
    chk({tag, "_pxdata"}, 32'(px_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_fcnt"}, 32'(frame_cnt), 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a byte, pixel or frame end.
  logic vs_prev = 1'b0;
  logic href_prev = 1'b0;
  int   vs_run = 0;
  int   href_run = 0;
  int   rise_cyc = 0;
  always @(negedge clk) begin
    frm_t f;
    if (rst) begin
      vs_prev = 1'b0;
      href_prev = 1'b0;
      vs_run = 0;
      href_run = 0;
    end else begin
      if (frame_done) begin
        if (exp_frm.size() == 0) begin
          chk("unexpected_frame_done", 32'd1, 32'd0);
        end else begin
          f = exp_frm.pop_front();
          chk("frame_cnt_at_done", 32'(frame_cnt), 32'(f.fcnt));
          chk("busy_at_done", 32'(busy), 32'(!f.last));
          chk("vsyn_at_done", 32'(cmos_vsyn), 32'(!f.last));
          chk("frame_length", 32'(cyc - rise_cyc), 32'(FLEN));
        end
      end
      if (cmos_vsyn && !vs_prev) rise_cyc = cyc;
      if (cmos_vsyn) begin
        vs_run++;
      end else if (vs_prev) begin
        chk("vsync_length", 32'(vs_run), 32'(VS_LEN));
        vs_run = 0;
      end
      if (cmos_href) begin
        href_run++;
        if (exp_byte.size() == 0) chk("unexpected_byte", 32'(cmos_data), 32'hFFFF_FFFF);
        else chk("data_byte", 32'(cmos_data), 32'(exp_byte.pop_front()));
      end else begin
        chk("data_zero_no_href", 32'(cmos_data), 32'd0);
        if (href_prev) chk("line_length", 32'(href_run), 32'(2 * COL));
        href_run = 0;
      end
      if (px_strb) begin
        chk("strb_inside_href", 32'(cmos_href), 32'd1);
        if (exp_px.size() == 0) chk("unexpected_pixel", 32'(px_data), 32'hFFFF_FFFF);
        else chk("px_data", 32'(px_data), 32'(exp_px.pop_front()));
      end
      vs_prev = cmos_vsyn;
      href_prev = cmos_href;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected completion, fails=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] c;
    logic [1:0]  m;
    int          seen_vs;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    wait_cycles(2);

    // Ramp, single frame.
    push_frame(2'd1, 16'h0000, 16'd1, 1'b1);
    do_start(2'd1, 16'h0000, 16'd1);
    wait_idle(200);
    chk("fcnt_after_ramp", 32'(frame_cnt), 32'd1);
    wait_cycles(3);

    // Colour bars, single frame.
    push_frame(2'd2, 16'h0000, 16'd1, 1'b1);
    do_start(2'd2, 16'h0000, 16'd1);
    wait_idle(200);
    wait_cycles(3);

    // LFSR, two identical frames back to back.
    push_frame(2'd0, 16'h0000, 16'd1, 1'b0);
    push_frame(2'd0, 16'h0000, 16'd2, 1'b1);
    do_start(2'd0, 16'h0000, 16'd2);
    wait_idle(400);
    chk("fcnt_after_lfsr", 32'(frame_cnt), 32'd2);
    wait_cycles(2);

    // Random single frames.
    for (int i = 0; i < 3; i++) begin
      m = 2'($urandom_range(0, 3));
      c = 16'($urandom);
      push_frame(m, c, 16'd1, 1'b1);
      do_start(m, c, 16'd1);
      wait_idle(200);
      wait_cycles(int'($urandom_range(1, 4)));
    end

    // Continuous run stopped partway through the third frame.
    m = 2'($urandom_range(0, 3));
    c = 16'($urandom);
    push_frame(m, c, 16'd1, 1'b0);
    push_frame(m, c, 16'd2, 1'b0);
    push_frame(m, c, 16'd3, 1'b1);
    do_start(m, c, 16'd0);
    wait_cycles(2 * int'(FLEN) + int'($urandom_range(15, 60)));
    stop = 1'b1;
    wait_cycles(1);
    stop = 1'b0;
    wait_idle(300);
    chk("fcnt_after_stop", 32'(frame_cnt), 32'd3);
    seen_vs = 0;
    repeat (20) begin
      @(negedge clk);
      if (cmos_vsyn) seen_vs++;
    end
    chk("no_vsync_after_stop", 32'(seen_vs), 32'd0);

    // Reset during the active bytes of line 2, then a clean frame.
    push_frame(2'd1, 16'h0000, 16'd1, 1'b1);
    do_start(2'd1, 16'h0000, 16'd1);
    wait_cycles(52);
    @(negedge clk);
    chk("href_before_rst", 32'(cmos_href), 32'd1);
    rst = 1'b1;
    exp_byte.delete();
    exp_px.delete();
    exp_frm.delete();
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("midframe_rst");
    rst = 1'b0;
    wait_cycles(2);
    c = 16'($urandom);
    push_frame(2'd3, c, 16'd1, 1'b1);
    do_start(2'd3, c, 16'd1);
    wait_idle(200);
    chk("fcnt_after_rst_frame", 32'(frame_cnt), 32'd1);
    wait_cycles(2);

    // Mode change and ignored start mid-frame; only the next frame sees the new mode.
    push_frame(2'd1, 16'h0000, 16'd1, 1'b0);
    push_frame(2'd2, 16'h0000, 16'd2, 1'b1);
    do_start(2'd1, 16'h0000, 16'd2);
    wait_cycles(40);
    mode = 2'd2;
    start = 1'b1;
    wait_cycles(1);
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_ignored_start", 32'(busy), 32'd1);
    chk("vsyn_after_ignored_start", 32'(cmos_vsyn), 32'd0);
    wait_idle(300);
    chk("fcnt_after_mode_change", 32'(frame_cnt), 32'd2);
    wait_cycles(3);

    chk("sb_bytes_drained", 32'(exp_byte.size()), 32'd0);
    chk("sb_pixels_drained", 32'(exp_px.size()), 32'd0);
    chk("sb_frames_drained", 32'(exp_frm.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
